// File: rtl/flood_pkg.sv
// Shared constants and debouncer state type for the Flood-It colour selector.
// Pure declarations, no logic, no flow control.
package flood_pkg;

  localparam logic [3:0] MIN_COLORS = 4'd3;
  localparam logic [3:0] MAX_COLORS = 4'd8;

  typedef enum logic [2:0] {
    DB_IDLE,
    DB_ARM,
    DB_PRESSED,
    DB_HELD,
    DB_RELEASE
  } db_state_t;

endpackage

// File: rtl/btn_debounce.sv
// Synchronises and debounces one raw pushbutton; emits a one-cycle press strobe.
// Latency pin edge to strobe 2 + DEBOUNCE_CYCLES + 1 cycles; no backpressure, strobes are never held.
module btn_debounce
  import flood_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic           sync_q1;
  logic           sync_q2;
  db_state_t      state;
  db_state_t      state_nxt;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  cnt_nxt;
  logic [CW-1:0]  cnt_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      state   <= DB_IDLE;
      cnt     <= '0;
    end else begin
      sync_q1 <= btn;
      sync_q2 <= sync_q1;
      state   <= state_nxt;
      cnt     <= cnt_nxt;
    end
  end

  // Saturate rather than wrap so a stalled compare can never alias back to zero.
  assign cnt_inc = (cnt == '1) ? cnt : cnt + CW'(1);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    press     = 1'b0;
    case (state)
      DB_IDLE: begin
        if (sync_q2) begin
          state_nxt = DB_ARM;
          cnt_nxt   = '0;
        end
      end
      DB_ARM: begin
        if (!sync_q2)             state_nxt = DB_IDLE;
        else if (cnt == CNT_LAST) state_nxt = DB_PRESSED;
        else                      cnt_nxt   = cnt_inc;
      end
      DB_PRESSED: begin
        press     = 1'b1;
        state_nxt = DB_HELD;
      end
      DB_HELD: begin
        if (!sync_q2) begin
          state_nxt = DB_RELEASE;
          cnt_nxt   = '0;
        end
      end
      DB_RELEASE: begin
        if (sync_q2)              state_nxt = DB_HELD;
        else if (cnt == CNT_LAST) state_nxt = DB_IDLE;
        else                      cnt_nxt   = cnt_inc;
      end
      default: state_nxt = DB_IDLE;
    endcase
  end

endmodule

// File: rtl/color_num_select.sv
// Flood-It colour-count selector (3..8) stepped by debounced up/down buttons, locked while a game runs.
// COLOR_NUM updates 1 cycle after a press strobe; no backpressure. COLOR_WRAP_EN: wrap 8<->3 instead of saturating.
module color_num_select
  import flood_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int RESET_COLORS    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       game_active,
  output logic [3:0] COLOR_NUM,
  output logic       num_changed
);

  localparam logic [3:0] RESET_VAL = 4'(RESET_COLORS);

  logic       up_press;
  logic       down_press;
  logic [3:0] color_nxt;
  logic       changed_nxt;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_up),
    .press (up_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_down (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_down),
    .press (down_press)
  );

  // Coincident strobes cancel; strobes during a game are dropped, not queued.
  always_comb begin
    color_nxt   = COLOR_NUM;
    changed_nxt = 1'b0;
    if (!game_active && (up_press ^ down_press)) begin
      if (up_press) begin
        if (COLOR_NUM < MAX_COLORS) begin
          color_nxt   = COLOR_NUM + 4'd1;
          changed_nxt = 1'b1;
        end
`ifdef COLOR_WRAP_EN
        else begin
          color_nxt   = MIN_COLORS;
          changed_nxt = 1'b1;
        end
`endif
      end else begin
        if (COLOR_NUM > MIN_COLORS) begin
          color_nxt   = COLOR_NUM - 4'd1;
          changed_nxt = 1'b1;
        end
`ifdef COLOR_WRAP_EN
        else begin
          color_nxt   = MAX_COLORS;
          changed_nxt = 1'b1;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      COLOR_NUM   <= RESET_VAL;
      num_changed <= 1'b0;
    end else begin
      COLOR_NUM   <= color_nxt;
      num_changed <= changed_nxt;
    end
  end

endmodule
